key_event_debouncer: RTL

//  Parametrised keypad debouncer between the keypad scanner and the display/entry logic.

---
 rtl/key_event_debouncer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/key_event_debouncer.sv
// Keypad debouncer: filters key_pressed/code_in into one-cycle press/release events
// with a latched key code and optional auto-repeat while held.
module key_event_debouncer #(
   parameter int unsigned CODE_W          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 960000,
   parameter int unsigned REPEAT_CYCLES   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_pressed,
   input  logic [CODE_W-1:0] code_in,
   output logic [CODE_W-1:0] code_out,
   output logic              press_pulse,
   output logic              release_pulse,
   output logic              held
);

   localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_DR > 2) ? MAX_DR : 2;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [CNT_W-1:0]  rpt, rpt_next;
   logic [CODE_W-1:0] cap, cap_next;
   logic [CODE_W-1:0] code_next;
   logic              press_next, release_next, held_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         rpt           <= '0;
         cap           <= '0;
         code_out      <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         held          <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         rpt           <= rpt_next;
         cap           <= cap_next;
         code_out      <= code_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         held          <= held_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      rpt_next     = rpt;
      cap_next     = cap;
      code_next    = code_out;
      press_next   = 1'b0;
      release_next = 1'b0;

      case (state)
         IDLE: begin
            if (key_pressed) begin
               state_next = DB_PRESS;
               cap_next   = code_in;
            end
         end
         DB_PRESS: begin
            if (!key_pressed) begin
               state_next = IDLE;
            end else if (code_in != cap) begin
               // a changing scan code restarts the stability window
               cap_next = code_in;
               cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = HELD;
               code_next  = cap;
               press_next = 1'b1;
            end else if (cnt < CNT_LAST) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            // key drop takes priority over a coincident repeat expiry
            if (!key_pressed) begin
               state_next = DB_RELEASE;
            end else if (code_in != cap) begin
               state_next   = DB_PRESS;
               cap_next     = code_in;
               release_next = 1'b1;
            end else if (REPEAT_CYCLES > 0) begin
               if (rpt == RPT_LAST) begin
                  press_next = 1'b1;
                  rpt_next   = '0;
               end else if (rpt < RPT_LAST) begin
                  rpt_next = rpt + CNT_W'(1);
               end
            end
         end
         DB_RELEASE: begin
            if (key_pressed) begin
               if (code_in == cap) begin
                  state_next = HELD;
               end else begin
                  state_next   = DB_PRESS;
                  cap_next     = code_in;
                  release_next = 1'b1;
               end
            end else if (cnt == CNT_LAST) begin
               state_next   = IDLE;
               release_next = 1'b1;
            end else if (cnt < CNT_LAST) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (state_next != state) begin
         cnt_next = '0;
         rpt_next = '0;
      end

      held_next = (state_next == HELD) || (state_next == DB_RELEASE);
   end

   a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(press_pulse && release_pulse));

endmodule
